ifu_pc_gen: RTL

Program-counter generator and fetch-redirect stage. It sits directly downstream of the execute-stage branch unit and consumes that unit's jump_flag/jump_addr pair. It issues sequential fetch addresses to the instruction fetch unit over a valid/ready handshake. On every redirect it pulses a pipeline flush and toggles a fetch epoch, so younger in-flight instructions and stale fetch responses get discarded.

---
 rtl/ifu_pc_gen_pkg.sv | 25 ++
 rtl/ifu_pc_redirect_cnt.sv | 27 ++
 rtl/ifu_pc_gen.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ifu_pc_gen_pkg.sv
// ============================================================================
// Module   : ifu_pc_gen_pkg
// Brief    : Shared constants and FSM encodings for the PC generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifu_pc_gen_pkg;

    localparam int          INST_ADDR_WIDTH = 32;
    localparam logic [31:0] ZeroWord        = 32'h0000_0000;
    localparam logic        JumpEnable      = 1'b1;

    localparam logic [INST_ADDR_WIDTH-1:0] PCG_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        PCG_BOOT = 2'd0,
        PCG_RUN  = 2'd1,
        PCG_HOLD = 2'd2,
        PCG_HALT = 2'd3
    } pcg_state_t;

endpackage

`default_nettype wire

// File: rtl/ifu_pc_redirect_cnt.sv
// ============================================================================
// Module   : ifu_pc_redirect_cnt
// Brief    : 32-bit saturating event counter with increment enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_pc_redirect_cnt
    import ifu_pc_gen_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inc_en,
    output logic [INST_ADDR_WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= ZeroWord;
        end else if (inc_en && (count != '1)) begin
            count <= count + 32'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ifu_pc_gen.sv
// ============================================================================
// Module   : ifu_pc_gen
// Brief    : Program-counter generator with fetch redirect, flush and epoch.
//            Optional misaligned-target trap enabled by IFU_MISALIGN_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_pc_gen
    import ifu_pc_gen_pkg::*;
#(
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = PCG_RESET_PC,
    parameter int                         PC_STEP  = 4
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       jump_flag_i,
    input  logic [INST_ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                       hold_i,
    output logic [INST_ADDR_WIDTH-1:0] pc_o,
    output logic                       pc_valid_o,
    input  logic                       pc_ready_i,
    output logic                       flush_o,
    output logic                       epoch_o,
    output logic [INST_ADDR_WIDTH-1:0] redirect_cnt_o
`ifdef IFU_MISALIGN_CHK_EN
    ,
    output logic                       exc_misalign_o,
    output logic [INST_ADDR_WIDTH-1:0] exc_addr_o
`endif
);

    localparam logic [INST_ADDR_WIDTH-1:0] PC_INC = INST_ADDR_WIDTH'(PC_STEP);

    pcg_state_t                 state;
    logic                       redirect_req;
    logic                       misaligned;
    logic                       redirect_ok;
    logic                       handshake;
    logic [INST_ADDR_WIDTH-1:0] jump_target;
    pcg_state_t                 resume_state;

    // The branch unit may raise jump_flag_i during BOOT; it carries no meaning yet.
    assign redirect_req = (jump_flag_i == JumpEnable) && (state != PCG_BOOT);
    assign handshake    = pc_valid_o && pc_ready_i;
    assign resume_state = hold_i ? PCG_HOLD : PCG_RUN;

`ifdef IFU_MISALIGN_CHK_EN
    assign misaligned  = (jump_addr_i[1:0] != 2'b00);
    assign jump_target = jump_addr_i;
`else
    assign misaligned  = 1'b0;
    assign jump_target = jump_addr_i & ~32'h0000_0003;
`endif

    assign redirect_ok = redirect_req && !misaligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= PCG_BOOT;
            pc_o       <= RESET_PC;
            pc_valid_o <= 1'b0;
            flush_o    <= 1'b0;
            epoch_o    <= 1'b0;
        end else begin
            flush_o <= redirect_req;
            if (redirect_req) begin
                epoch_o <= ~epoch_o;
            end

            // A redirect always beats the sequential increment.
            if (redirect_ok) begin
                pc_o <= jump_target;
            end else if (handshake) begin
                pc_o <= pc_o + PC_INC;
            end

`ifdef IFU_MISALIGN_CHK_EN
            if (redirect_req && misaligned) begin
                state      <= PCG_HALT;
                pc_valid_o <= 1'b0;
            end else if ((state == PCG_HALT) && !redirect_ok) begin
                state      <= PCG_HALT;
                pc_valid_o <= 1'b0;
            end else begin
                state      <= resume_state;
                pc_valid_o <= !hold_i;
            end
`else
            state      <= resume_state;
            pc_valid_o <= !hold_i;
`endif
        end
    end

`ifdef IFU_MISALIGN_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_misalign_o <= 1'b0;
            exc_addr_o     <= ZeroWord;
        end else begin
            exc_misalign_o <= redirect_req && misaligned;
            if (redirect_req && misaligned) begin
                exc_addr_o <= jump_addr_i;
            end
        end
    end
`endif

    ifu_pc_redirect_cnt u_redirect_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_en (redirect_req),
        .count  (redirect_cnt_o)
    );

endmodule

`default_nettype wire
